mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single off-chip memory port between the instruction cache (read-only) and the data cache (read/write-back).
- Sits between the two cache controllers and the slow memory model. Each cache sees a private memory interface with unchanged timing except for queueing delay.
- Round-robin fairness on simultaneous requests. Two saturating grant counters for performance reporting.

Parameters:
- ADDR_W, 28: block address width (128-bit block granularity).
- DATA_W, 128: block data width.
- CNT_W, 16: width of the grant counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- i_read  in  1  I-cache block read request, held until i_ready
- i_addr  in  ADDR_W  I-cache block address
- i_rdata  out  DATA_W  read data to I-cache
- i_ready  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache block read request, held until d_ready
- d_write  in  1  D-cache block write request, held until d_ready
- d_addr  in  ADDR_W  D-cache block address
- d_wdata  in  DATA_W  D-cache write data
- d_rdata  out  DATA_W  read data to D-cache
- d_ready  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion pulse
- i_grant_cnt  out  CNT_W  count of completed I-cache transactions
- d_grant_cnt  out  CNT_W  count of completed D-cache transactions

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=I.
  - mem_read, mem_write, mem_addr, mem_wdata all 0.
  - Both counters 0.
  - i_ready=d_ready=0; i_rdata=d_rdata=0.
- FSM states:
  - IDLE: sample requests.
    - i_req = i_read; d_req = d_read | d_write.
    - Only one requester active: grant it.
    - Both active: grant the one not equal to last_grant. After reset this is D.
    - Granting to I gives GRANT_I; granting to D gives GRANT_D. No request: stay in IDLE.
  - GRANT_I / GRANT_D: mem_* outputs are registered copies of the granted requester's fields, captured on the IDLE->GRANT edge.
    - mem_read/mem_write go high on the cycle after the request is seen (1-cycle arbitration latency).
    - They hold stable until mem_ready. Address and data are frozen even if the requester's inputs change.
    - On mem_ready: drop strobes next edge, update last_grant, increment the matching counter, go to RELEASE.
  - RELEASE: one cycle, all strobes 0, then IDLE. This gives the requester a cycle to deassert its request, so a stale request is never re-granted.
- Completion path (combinational):
  - x_ready = mem_ready & (state==GRANT_x).
  - x_rdata = mem_rdata when GRANT_x, else 0.
  - The non-granted requester sees ready=0.
- D-cache read and write both asserted: write wins (mem_write=1, mem_read=0). This is a protocol error but must be deterministic.
- Requester drops its request while granted: the transaction still completes and ready still pulses.
- Minimum spacing: mem_ready at cycle t gives the next grant strobe at t+3 at the earliest (GRANT->RELEASE->IDLE->GRANT).
- mem_ready while in IDLE or RELEASE: ignored. No ready pulse and no counter change.
- Counters saturate at all-ones and never wrap.
- Reset mid-transaction: immediate abort to reset values. Requesters must re-issue.

Decomposition:
- Shared package:
  - state encoding constants: ST_IDLE=2'd0, ST_GRANT_I=2'd1, ST_GRANT_D=2'd2, ST_RELEASE=2'd3
  - grant-ID constants: GNT_I=1'b0, GNT_D=1'b1
- One sub-module, sat_counter (CNT_W, increment enable, async active-low reset), instantiated twice.
- FSM and muxing stay in the top module.

Test Plan:
1. I-only read, addr 0x0000040, memory latency 8. Required response:
   - mem_read rises 1 cycle after i_read.
   - mem_addr=0x0000040.
   - i_ready pulses with mem_ready; i_rdata=mem_rdata=0x...CCCC.
   - d_ready stays 0; i_grant_cnt=1.
2. Simultaneous I read 0x10 and D write 0x20 (wdata 0x8763) right after reset. Required response:
   - D is granted first: mem_write=1, mem_addr=0x20, mem_wdata=0x8763.
   - After d_ready plus the RELEASE cycle, I is granted: mem_read=1, mem_addr=0x10.
   - Counters end at 1/1.
3. Both requesters held continuously for 6 transactions:
   - Grants alternate D,I,D,I,D,I.
   - Each grant strobe starts at least 3 cycles after the previous mem_ready.
4. D read, then d_addr changed mid-grant:
   - mem_addr stays at the originally captured value until mem_ready.
5. Spurious mem_ready in IDLE:
   - No ready pulse, counters unchanged.
   - Assert rst low during GRANT_I: all mem_* outputs go to 0 immediately; state returns to IDLE; counters return to 0.
6. Force d_grant_cnt to 0xFFFE and complete 3 D transactions:
   - Counter reads 0xFFFF and holds.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the off-chip memory port arbiter.
// FSM state and grant-owner identifiers.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT_I = 2'd1,
      ST_GRANT_D = 2'd2,
      ST_RELEASE = 2'd3
   } state_e;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_counter.sv
// Saturating event counter used for per-requester grant statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache and D-cache.
// Requests are captured on grant so the memory sees a frozen transaction.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [CNT_W-1:0]  i_grant_cnt,
   output logic [CNT_W-1:0]  d_grant_cnt
);

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic i_req, d_req, pick_d;
   logic i_done, d_done;

   assign i_req  = i_read;
   assign d_req  = d_read | d_write;
   // On a tie, the requester that did not win last time gets the port.
   assign pick_d = d_req & (~i_req | (last_q == GNT_I));

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (i_req | d_req) begin
               if (pick_d) begin
                  state_d = ST_GRANT_D;
                  rd_d    = ~d_write;
                  wr_d    = d_write;
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
               end else begin
                  state_d = ST_GRANT_I;
                  rd_d    = 1'b1;
                  wr_d    = 1'b0;
                  addr_d  = i_addr;
                  wdata_d = '0;
               end
            end
         end
         ST_GRANT_I, ST_GRANT_D: begin
            if (mem_ready) begin
               state_d = ST_RELEASE;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               last_d  = (state_q == ST_GRANT_D) ? GNT_D : GNT_I;
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         last_q  <= GNT_I;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign i_done = mem_ready & (state_q == ST_GRANT_I);
   assign d_done = mem_ready & (state_q == ST_GRANT_D);

   assign i_ready = i_done;
   assign d_ready = d_done;
   assign i_rdata = (state_q == ST_GRANT_I) ? mem_rdata : '0;
   assign d_rdata = (state_q == ST_GRANT_D) ? mem_rdata : '0;

   assign mem_read  = rd_q;
   assign mem_write = wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   sat_counter #(.CNT_W(CNT_W)) u_i_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (i_done),
      .cnt_o (i_grant_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_d_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (d_done),
      .cnt_o (d_grant_cnt)
   );

endmodule
